// File: rtl/game_pkg.sv
// Shared types for the game command sequencer.
// Command bundle, counter modes and sequencer states.
package game_pkg;

    localparam int SIZE    = 4;
    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        UP1 = 2'b00,
        UP2 = 2'b01,
        DN1 = 2'b10,
        DN2 = 2'b11
    } game_mode_e;

    typedef struct packed {
        game_mode_e         mode;
        logic               load;
        logic [SIZE-1:0]    value;
        logic [DWELL_W-1:0] dwell;
    } game_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        OVER = 2'b10
    } seq_state_e;

endpackage

// File: rtl/game_cmd_fifo.sv
// Synchronous command FIFO with flush.
// Flush wins over push/pop in the same cycle.
import game_pkg::*;

module game_cmd_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  game_cmd_t     din,
    output game_cmd_t     dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    game_cmd_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset, level gates validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/game_cmd_sequencer.sv
// Feeds queued host commands to the game counter stage.
// Each command is held for its dwell time; GAMEOVER flushes.
import game_pkg::*;

module game_cmd_sequencer #(
    parameter int DEPTH = 8,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic               cmd_load,
    input  logic [SIZE-1:0]    cmd_value,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               GAMEOVER,
    output logic [1:0]         control,
    output logic [SIZE-1:0]    INIT_l,
    output logic               INIT_c,
    output logic               busy,
    output logic [LW-1:0]      fifo_level
);

    seq_state_e         state;
    seq_state_e         next_state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               pop;
    logic               push;
    logic               full;
    logic               empty;
    game_cmd_t          din;
    game_cmd_t          head;

    assign din.mode  = game_mode_e'(cmd_mode);
    assign din.load  = cmd_load;
    assign din.value = cmd_value;
    assign din.dwell = cmd_dwell;

    assign cmd_ready = !full && (state != OVER);
    assign push      = cmd_valid && cmd_ready && !GAMEOVER;
    assign busy      = (state == RUN);

    game_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .flush(GAMEOVER),
        .din  (din),
        .dout (head),
        .full (full),
        .empty(empty),
        .level(fifo_level)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and pop decision; GAMEOVER overrides everything.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (GAMEOVER) begin
                    next_state = OVER;
                end else if (!empty) begin
                    pop        = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (GAMEOVER) begin
                    next_state = OVER;
                end else if (dwell_cnt <= DWELL_W'(1)) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            OVER: begin
                if (!GAMEOVER) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output registers and dwell countdown; a zero dwell runs one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            control   <= UP1;
            INIT_l    <= '0;
            INIT_c    <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            INIT_c <= 1'b0;
            if (pop) begin
                control   <= head.mode;
                INIT_l    <= head.value;
                INIT_c    <= head.load;
                dwell_cnt <= (head.dwell == '0) ? DWELL_W'(1) : head.dwell;
            end else if (next_state == RUN) begin
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end else begin
                dwell_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_game_cmd_sequencer.sv
// Randomized and directed bench for game_cmd_sequencer.
// Reference is a command queue plus remaining-dwell model.
module tb_game_cmd_sequencer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'b00;
    logic       cmd_load = 1'b0;
    logic [3:0] cmd_value = 4'h0;
    logic [7:0] cmd_dwell = 8'h00;
    logic       GAMEOVER = 1'b0;
    logic [1:0] control;
    logic [3:0] INIT_l;
    logic       INIT_c;
    logic       busy;
    logic [3:0] fifo_level;

    game_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_load  (cmd_load),
        .cmd_value (cmd_value),
        .cmd_dwell (cmd_dwell),
        .GAMEOVER  (GAMEOVER),
        .control   (control),
        .INIT_l    (INIT_l),
        .INIT_c    (INIT_c),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int load;
        int value;
        int dwell;
    } mcmd_t;

    mcmd_t q[$];
    int    m_remain;
    bit    m_over;
    int    m_ctrl;
    int    m_initl;
    int    m_initc;
    bit    m_acc;

    int n_vec = 0;
    int n_err = 0;
    int n_pulse = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !m_over && (q.size() < DEPTH);
    endfunction

    task automatic m_reset();
        q.delete();
        m_remain = 0;
        m_over   = 1'b0;
        m_ctrl   = 0;
        m_initl  = 0;
        m_initc  = 0;
        m_acc    = 1'b0;
    endtask

    // One clock edge of the reference: flush, else start/continue/finish.
    task automatic model_edge();
        mcmd_t c;
        bit    rdy;
        rdy   = m_ready();
        m_acc = cmd_valid && rdy && !GAMEOVER;
        if (GAMEOVER) begin
            q.delete();
            m_remain = 0;
            m_over   = 1'b1;
            m_initc  = 0;
        end else if (m_over) begin
            m_over  = 1'b0;
            m_initc = 0;
        end else begin
            if (m_remain <= 1 && q.size() > 0) begin
                c        = q.pop_front();
                m_ctrl   = c.mode;
                m_initl  = c.value;
                m_initc  = c.load;
                m_remain = (c.dwell == 0) ? 1 : c.dwell;
            end else begin
                m_initc = 0;
                if (m_remain > 0) m_remain--;
            end
            if (m_acc) begin
                c.mode  = int'(cmd_mode);
                c.load  = int'(cmd_load);
                c.value = int'(cmd_value);
                c.dwell = int'(cmd_dwell);
                q.push_back(c);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("control", control, m_ctrl);
        check("INIT_l", INIT_l, m_initl);
        check("INIT_c", INIT_c, m_initc);
        check("busy", busy, m_remain > 0);
        check("fifo_level", fifo_level, q.size());
        check("cmd_ready", cmd_ready, m_ready());
        if (INIT_c === 1'b1) n_pulse++;
    endtask

    task automatic push_cmd(input int mode, input int load,
                            input int value, input int dwell);
        int n;
        cmd_mode  = 2'(mode);
        cmd_load  = 1'(load);
        cmd_value = 4'(value);
        cmd_dwell = 8'(dwell);
        cmd_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 400);
        if (!m_acc) check("push_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int p0;
        int bsum;
        int n;

        m_reset();
        #2 reset = 1'b0;
        #1;
        check("por_control", control, 0);
        check("por_INIT_l", INIT_l, 0);
        check("por_INIT_c", INIT_c, 0);
        check("por_busy", busy, 0);
        check("por_level", fifo_level, 0);
        #9 reset = 1'b1;
        check("por_ready", cmd_ready, 1);
        tick();

        // Single command: UP2, load 5, dwell 3.
        push_cmd(1, 1, 5, 3);
        tick();
        check("ex_control", control, 1);
        check("ex_INIT_l", INIT_l, 5);
        check("ex_INIT_c", INIT_c, 1);
        bsum = busy;
        p0 = n_pulse;
        for (int i = 0; i < 6; i++) begin
            tick();
            bsum += int'(busy);
        end
        check("ex_busy_cycles", bsum, 3);
        check("ex_single_pulse", n_pulse - p0, 0);
        check("ex_hold_control", control, 1);
        check("ex_idle", busy, 0);

        // Back-to-back dwell 2, 1, 0.
        p0 = n_pulse;
        push_cmd(2, 1, 3, 2);
        push_cmd(3, 1, 7, 1);
        push_cmd(0, 1, 9, 0);
        for (int i = 0; i < 6; i++) tick();
        check("b2b_pulses", n_pulse - p0, 3);
        check("b2b_last_ctrl", control, 0);

        // Asynchronous reset in the middle of a command.
        push_cmd(3, 1, 9, 50);
        push_cmd(2, 0, 1, 4);
        push_cmd(1, 0, 2, 4);
        tick();
        check("mid_busy_pre", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_control", control, 0);
        check("rst_INIT_c", INIT_c, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        m_reset();
        #2 reset = 1'b1;
        tick();

        // Fill to DEPTH behind a long command; ninth must wait.
        push_cmd(3, 1, 4'hA, 255);
        tick();
        for (int i = 0; i < DEPTH; i++) push_cmd(i % 4, 1, i, 3);
        check("full_level", fifo_level, DEPTH);
        check("full_ready", cmd_ready, 0);
        push_cmd(1, 1, 4'hF, 3);
        check("full_accepted", m_acc, 1);
        check("full_level_after", fifo_level, DEPTH);

        // GAMEOVER while running with a full queue.
        GAMEOVER = 1'b1;
        tick();
        check("go_level", fifo_level, 0);
        check("go_ready", cmd_ready, 0);
        check("go_INIT_c", INIT_c, 0);
        GAMEOVER = 1'b0;
        tick();
        check("go_idle", busy, 0);
        check("go_ready_back", cmd_ready, 1);
        push_cmd(2, 1, 6, 6);
        check("go_push_level", fifo_level, 1);

        // Simultaneous push and pop at level 3.
        tick();
        push_cmd(0, 1, 1, 2);
        push_cmd(1, 1, 2, 2);
        push_cmd(2, 1, 3, 2);
        n = 0;
        while (m_remain != 1 && n < 20) begin
            tick();
            n++;
        end
        check("pp_wait", m_remain, 1);
        check("pp_level_pre", fifo_level, 3);
        cmd_mode  = 2'd3;
        cmd_load  = 1'b1;
        cmd_value = 4'd4;
        cmd_dwell = 8'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("pp_level", fifo_level, 3);
        for (int i = 0; i < 12; i++) tick();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_mode  = 2'($urandom_range(0, 3));
            cmd_load  = 1'($urandom_range(0, 1));
            cmd_value = 4'($urandom_range(0, 15));
            cmd_dwell = ($urandom_range(0, 9) == 0) ?
                        8'($urandom_range(0, 12)) :
                        8'($urandom_range(0, 3));
            GAMEOVER  = ($urandom_range(0, 63) == 0);
            tick();
        end
        cmd_valid = 1'b0;
        GAMEOVER  = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
